// File: rtl/nios2_param_pkg.sv
//==============================================================================
// nios2_param_pkg: register map, bit indices and FSM states for the writer.
// Rev 1.0
//==============================================================================
`default_nettype none

package nios2_param_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_CTRL    = 2'd1;
   localparam logic [1:0] ADDR_LAST    = 2'd2;
   localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

   localparam int CTRL_GO     = 0;
   localparam int CTRL_CLR    = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam int STAT_BUSY   = 0;
   localparam int STAT_DONE   = 1;
   localparam int STAT_ERR    = 2;
   localparam int STAT_IRQ_EN = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/nios2_param_timeout_ctr.sv
//==============================================================================
// nios2_param_timeout_ctr: handshake timeout down-counter; a zero load never expires.
// Rev 1.0
//==============================================================================
`default_nettype none

module nios2_param_timeout_ctr #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             expire_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Holding at zero keeps a TIMEOUT of 0 from wrapping into a finite timeout.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = dec_i && (cnt_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/nios2_param_writer.sv
//==============================================================================
// nios2_param_writer: Avalon-MM slave pushing a staged parameter over valid/ready.
// Optional handshake timeout enabled by NIOS2_PARAM_WRITER_TIMEOUT_EN.  Rev 1.0
//==============================================================================
`default_nettype none

module nios2_param_writer
   import nios2_param_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int TIMEOUT_WIDTH = 16,
   parameter int TIMEOUT_RESET = 1000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic                  irq,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] last_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  done_q;
   logic                  irq_en_q;
   logic [31:0]           readdata_q, readdata_d;

   logic busy, wr, wr_ctrl, go, clr, handshake, expire, err;
   logic [TIMEOUT_WIDTH-1:0] timeout_val;
   logic unused_ok;

   assign busy      = (state_q == XFER);
   assign wr        = chipselect && !write_n;
   assign wr_ctrl   = wr && (address == ADDR_CTRL);
   assign go        = wr_ctrl && writedata[CTRL_GO] && !busy;
   assign clr       = wr_ctrl && writedata[CTRL_CLR];
   assign handshake = busy && out_ready;

`ifdef NIOS2_PARAM_WRITER_TIMEOUT_EN
   logic [TIMEOUT_WIDTH-1:0] timeout_q;
   logic                     err_q;

   nios2_param_timeout_ctr #(
      .WIDTH(TIMEOUT_WIDTH)
   ) u_timeout_ctr (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (go),
      .load_val_i (timeout_q),
      .dec_i      (busy && !out_ready),
      .expire_o   (expire)
   );

   // expire already requires out_ready low, so a simultaneous handshake wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timeout_q <= TIMEOUT_WIDTH'(TIMEOUT_RESET);
         err_q     <= 1'b0;
      end else begin
         if (wr && (address == ADDR_TIMEOUT)) begin
            timeout_q <= writedata[TIMEOUT_WIDTH-1:0];
         end
         if (expire) begin
            err_q <= 1'b1;
         end else if (clr) begin
            err_q <= 1'b0;
         end
      end
   end

   assign timeout_val = timeout_q;
   assign err         = err_q;
   assign unused_ok   = ^writedata;
`else
   assign expire      = 1'b0;
   assign err         = 1'b0;
   assign timeout_val = '0;
   assign unused_ok   = ^{writedata, TIMEOUT_WIDTH'(TIMEOUT_RESET)};
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (go) state_d = XFER;
         XFER:    if (handshake || expire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA: readdata_d[DATA_WIDTH-1:0] = data_q;
         ADDR_CTRL: begin
            readdata_d[STAT_BUSY]   = busy;
            readdata_d[STAT_DONE]   = done_q;
            readdata_d[STAT_ERR]    = err;
            readdata_d[STAT_IRQ_EN] = irq_en_q;
         end
         ADDR_LAST:    readdata_d[DATA_WIDTH-1:0]    = last_q;
         ADDR_TIMEOUT: readdata_d[TIMEOUT_WIDTH-1:0] = timeout_val;
         default:      readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         data_q     <= '0;
         last_q     <= '0;
         out_data_q <= '0;
         done_q     <= 1'b0;
         irq_en_q   <= 1'b0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         readdata_q <= readdata_d;
         if (wr && (address == ADDR_DATA) && !busy) begin
            data_q <= writedata[DATA_WIDTH-1:0];
         end
         if (go) begin
            out_data_q <= data_q;
         end
         if (handshake) begin
            last_q <= out_data_q;
         end
         if (handshake) begin
            done_q <= 1'b1;
         end else if (clr) begin
            done_q <= 1'b0;
         end
         if (wr_ctrl) begin
            irq_en_q <= writedata[CTRL_IRQ_EN];
         end
      end
   end

   assign readdata  = readdata_q;
   assign out_data  = out_data_q;
   assign out_valid = busy;
   assign irq       = irq_en_q && (done_q || err);

endmodule

`default_nettype wire

// File: tb/tb_nios2_param_writer.sv
//==============================================================================
// tb_nios2_param_writer: directed self-checking bench for nios2_param_writer.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_nios2_param_writer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic        irq;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int n_pass = 0;
   int n_total = 0;
   logic [31:0] rd;

   nios2_param_writer #(
      .DATA_WIDTH    (8),
      .TIMEOUT_WIDTH (16),
      .TIMEOUT_RESET (1000)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      @(posedge clk);
      #1;
      d          = readdata;
      chipselect = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_readdata", readdata, 32'h0);
      check("rst_out_valid", {31'd0, out_valid}, 32'h0);
      check("rst_out_data", {24'd0, out_data}, 32'h0);
      check("rst_irq", {31'd0, irq}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      bus_read(2'd1, rd); check("rst_status", rd, 32'h0);
      bus_read(2'd0, rd); check("rst_data", rd, 32'h0);
      bus_read(2'd2, rd); check("rst_last", rd, 32'h0);
      bus_read(2'd3, rd);
`ifdef NIOS2_PARAM_WRITER_TIMEOUT_EN
      check("rst_timeout", rd, 32'd1000);
`else
      check("rst_timeout", rd, 32'd0);
`endif

      // Single-cycle transfer with out_ready already high
      bus_write(2'd0, 32'h0000_00A5);
      out_ready = 1'b1;
      bus_write(2'd1, 32'h1);
      check("a5_valid_hi", {31'd0, out_valid}, 32'h1);
      check("a5_data", {24'd0, out_data}, 32'hA5);
      @(posedge clk); #1;
      check("a5_valid_lo", {31'd0, out_valid}, 32'h0);
      bus_read(2'd1, rd); check("a5_status", rd, 32'h2);
      bus_read(2'd2, rd); check("a5_last", rd, 32'hA5);

      // Stalled transfer: out_ready low for 5 edges, DATA write while busy
      out_ready = 1'b0;
      bus_write(2'd0, 32'h0000_003C);
      bus_write(2'd1, 32'h1);
      for (int i = 0; i < 4; i++) begin
         check("3c_valid_hold", {31'd0, out_valid}, 32'h1);
         check("3c_data_hold", {24'd0, out_data}, 32'h3C);
         @(posedge clk); #1;
      end
      bus_write(2'd0, 32'h0000_00FF);
      check("3c_valid_5", {31'd0, out_valid}, 32'h1);
      check("3c_data_5", {24'd0, out_data}, 32'h3C);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("3c_valid_lo", {31'd0, out_valid}, 32'h0);
      out_ready = 1'b0;
      bus_read(2'd0, rd); check("busy_data_write_ignored", rd, 32'h3C);
      bus_read(2'd2, rd); check("3c_last", rd, 32'h3C);
      bus_read(2'd1, rd); check("3c_status", rd, 32'h2);

`ifdef NIOS2_PARAM_WRITER_TIMEOUT_EN
      // Timeout with T=4, then handshake on the 4th edge
      bus_write(2'd1, 32'h2);
      bus_write(2'd3, 32'd4);
      bus_read(2'd3, rd); check("to_readback", rd, 32'd4);
      bus_write(2'd1, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      check("to_valid_3", {31'd0, out_valid}, 32'h1);
      @(posedge clk); #1;
      check("to_valid_4", {31'd0, out_valid}, 32'h0);
      bus_read(2'd1, rd); check("to_status_err", rd, 32'h4);
      bus_read(2'd2, rd); check("to_last_kept", rd, 32'h3C);
      bus_write(2'd1, 32'h2);
      bus_write(2'd1, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("tohs_valid_lo", {31'd0, out_valid}, 32'h0);
      out_ready = 1'b0;
      bus_read(2'd1, rd); check("tohs_status_done", rd, 32'h2);
      bus_write(2'd3, 32'd0);
`endif

      // Interrupt, CLR, GO while busy
      bus_write(2'd1, 32'h2);
      check("clr_irq", {31'd0, irq}, 32'h0);
      bus_read(2'd1, rd); check("clr_status", rd, 32'h0);
      bus_write(2'd1, 32'h4);
      check("irqen_irq_lo", {31'd0, irq}, 32'h0);
      bus_write(2'd1, 32'h5);
      check("irq_go_valid", {31'd0, out_valid}, 32'h1);
      bus_write(2'd1, 32'h5);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("irq_xfer_done", {31'd0, out_valid}, 32'h0);
      check("irq_set", {31'd0, irq}, 32'h1);
      @(posedge clk); #1;
      check("no_second_xfer", {31'd0, out_valid}, 32'h0);
      out_ready = 1'b0;
      bus_read(2'd1, rd); check("irq_status", rd, 32'hA);
      bus_write(2'd1, 32'h6);
      check("irq_cleared", {31'd0, irq}, 32'h0);

      // GO and CLR together; then wait forever with out_ready low
      bus_write(2'd1, 32'h3);
      check("goclr_valid", {31'd0, out_valid}, 32'h1);
      check("goclr_data", {24'd0, out_data}, 32'h3C);
      bus_read(2'd1, rd); check("goclr_status", rd, 32'h1);
      repeat (2000) @(posedge clk);
      #1;
      check("long_wait_valid", {31'd0, out_valid}, 32'h1);
      bus_read(2'd1, rd); check("long_wait_status", rd, 32'h1);
      bus_write(2'd3, 32'd5);
      bus_read(2'd3, rd);
`ifdef NIOS2_PARAM_WRITER_TIMEOUT_EN
      check("timeout_write", rd, 32'd5);
`else
      check("timeout_write_ignored", rd, 32'd0);
`endif

      // Asynchronous reset mid-transfer
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, out_valid}, 32'h0);
      check("async_rst_data", {24'd0, out_data}, 32'h0);
      check("async_rst_readdata", readdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      bus_read(2'd1, rd); check("post_rst_status", rd, 32'h0);
      bus_read(2'd0, rd); check("post_rst_data", rd, 32'h0);
      bus_read(2'd2, rd); check("post_rst_last", rd, 32'h0);
      bus_read(2'd3, rd);
`ifdef NIOS2_PARAM_WRITER_TIMEOUT_EN
      check("post_rst_timeout", rd, 32'd1000);
`else
      check("post_rst_timeout", rd, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
